tile_turn_ctrl: RTL and testbench
=================================

Name: tile_turn_ctrl

Overview:
- Sequences one player turn of the tile-matching game while the game-mode FSM reports in-game.
- Accepts two tile selections and fetches each tile's value from the board memory.
- Compares the two values, then either marks the pair matched or shows the pair for a fixed time and hides it again.
- Counts pairs and moves, and raises gameOver to the game-mode FSM when the board is cleared.

Parameters:
- NUM_TILES, 16, number of tiles on the board (even, ≤ 2^IDX_W).
- IDX_W, 4, tile index width.
- VAL_W, 3, tile face value width.
- SHOW_CYCLES, 25000000, cycles a mismatched pair stays revealed (0.5 s at 50 MHz); ≥ 1.
- MAX_MISSES, 8, mismatch limit (used only with MOVE_LIMIT_EN).

Ports:
- CLOCK_50, in, 1, system clock; all state changes on its rising edge.
- resetn, in, 1, asynchronous, active-low reset.
- ingameOn, in, 1, level from the game-mode FSM; low forces IDLE.
- sel_valid, in, 1, one-cycle selection pulse from cursor logic.
- sel_idx, in, IDX_W, selected tile index, qualified by sel_valid.
- rd_en, out, 1, board memory read strobe.
- rd_addr, out, IDX_W, board memory read address.
- rd_data, in, VAL_W, tile value; valid the cycle after rd_en.
- revealed, out, NUM_TILES, tiles currently face-up but not matched.
- matched, out, NUM_TILES, tiles permanently matched.
- busy, out, 1, high when selections are being ignored.
- score, out, IDX_W, matched pair count.
- moves, out, 8, completed turns; saturates at 255.
- gameOver, out, 1, level; board cleared (or move limit reached).

Behaviour:
- Reset values (async, resetn = 0): state IDLE; all outputs 0.
- States:
  - IDLE → PICK1 when ingameOn = 1. The IDLE → PICK1 edge clears revealed, matched, score and moves.
  - PICK1 / PICK2: wait for a valid selection. A selection is accepted only if sel_idx < NUM_TILES, and revealed[sel_idx] = 0, and matched[sel_idx] = 0.
    - On accept: set revealed[sel_idx], latch idx1/idx2, go to FETCH1/FETCH2.
    - Invalid selections are ignored with no state change.
  - FETCH1 / FETCH2: one cycle with rd_en = 1 and rd_addr = latched index → LATCH1 / LATCH2.
  - LATCH1 / LATCH2: capture rd_data into val1/val2 → PICK2 / CMP.
  - CMP (one cycle): moves += 1 (saturating).
    - If val1 == val2: set matched bits and clear revealed bits for idx1 and idx2; score += 1; go to DONE if score reaches NUM_TILES/2, else PICK1.
    - If val1 != val2: load the show timer with SHOW_CYCLES − 1 → SHOW.
  - SHOW: timer decrements each cycle. At 0, clear revealed for idx1 and idx2 → PICK1.
  - DONE: gameOver = 1; remains in DONE until ingameOn = 0.
- Outputs:
  - rd_en and rd_addr are driven only in FETCHx; rd_addr = 0 elsewhere.
  - busy = 1 in every state except PICK1 and PICK2.
  - sel_valid while busy is dropped, not queued.
- ingameOn = 0 in any state → IDLE on the next edge; gameOver drops on that edge. Masks, score and moves hold until the next game start.
- Clear-after-match latency: accept of second tile → CMP is 3 cycles; matched updates on the CMP edge.
- Simultaneous events:
  - ingameOn falling has priority over every transition.
  - A selection arriving on the same cycle the SHOW timer expires is ignored.
- An async reset mid-turn abandons the turn with no memory read outstanding; a read issued at reset is discarded.

Optional Feature:
- MOVE_LIMIT_EN defined: adds an internal miss counter (width covers MAX_MISSES), incremented on each mismatch in CMP. When a SHOW completes and misses == MAX_MISSES, go to DONE instead of PICK1 and assert gameOver. The counter clears on IDLE → PICK1.
- MOVE_LIMIT_EN undefined: no miss counter, and DONE is reachable only by clearing the board.

Decomposition:
- Shared package tile_game_pkg holds:
  - state encoding localparams (IDLE, PICK1, FETCH1, LATCH1, PICK2, FETCH2, LATCH2, CMP, SHOW, DONE);
  - default NUM_TILES, IDX_W and VAL_W constants;
  - the SHOW_CYCLES default.
- One sub-module, tile_show_timer: a loadable down-counter with load and done outputs, reused later for animations.

Test Plan:
- Reset, then ingameOn = 1; select 3 then 7 with rd_data 5 and 5 → rd_en pulses at addr 3 then addr 7; matched = 0x0088; score = 1; moves = 1; revealed = 0.
- Select 2 then 4 with values 1 and 6, SHOW_CYCLES = 10 → revealed = 0x0014 for exactly 10 cycles after CMP, then 0; moves = 2; score unchanged.
- Select the same tile twice, select an already-matched tile, then select idx ≥ NUM_TILES → all rejected; state stays PICK2 / PICK1; no rd_en.
- Clear all 8 pairs → score = 8, gameOver = 1 held; ingameOn = 0 → gameOver = 0 next cycle; state IDLE.
- Drop ingameOn during SHOW, then re-raise → IDLE, then PICK1 with revealed, matched, score and moves all 0.
- MOVE_LIMIT_EN with MAX_MISSES = 2: two mismatches → gameOver = 1 after the second SHOW expires; sel_valid pulses during busy are ignored throughout.

Source files
------------

// File: rtl/tile_game_pkg.sv
// Shared constants and state encoding for the tile-matching game blocks.
// Pure declarations: no logic, no latency, no flow control.
package tile_game_pkg;

    localparam int NUM_TILES_DEF   = 16;
    localparam int IDX_W_DEF       = 4;
    localparam int VAL_W_DEF       = 3;
    localparam int SHOW_CYCLES_DEF = 25000000;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        PICK1  = 4'd1,
        FETCH1 = 4'd2,
        LATCH1 = 4'd3,
        PICK2  = 4'd4,
        FETCH2 = 4'd5,
        LATCH2 = 4'd6,
        CMP    = 4'd7,
        SHOW   = 4'd8,
        DONE   = 4'd9
    } turn_state_t;

    // Down-counter width able to hold cycles-1; never narrower than one bit.
    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/tile_show_timer.sv
// Loadable down-counter: load takes effect on the next edge, then counts down while enabled.
// done is high while the count is zero; the counter holds at zero, no flow control.
module tile_show_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/tile_turn_ctrl.sv
// Turn sequencer: two picks, one board read each, compare, then match or timed show; CMP is 3 cycles after the 2nd accept.
// Selections are dropped (never queued) while busy. Optional MOVE_LIMIT_EN ends the game after MAX_MISSES mismatches.
module tile_turn_ctrl
    import tile_game_pkg::*;
#(
    parameter int NUM_TILES   = NUM_TILES_DEF,
    parameter int IDX_W       = IDX_W_DEF,
    parameter int VAL_W       = VAL_W_DEF,
    parameter int SHOW_CYCLES = SHOW_CYCLES_DEF
`ifdef MOVE_LIMIT_EN
    ,
    parameter int MAX_MISSES  = 8
`endif
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 ingameOn,
    input  logic                 sel_valid,
    input  logic [IDX_W-1:0]     sel_idx,
    output logic                 rd_en,
    output logic [IDX_W-1:0]     rd_addr,
    input  logic [VAL_W-1:0]     rd_data,
    output logic [NUM_TILES-1:0] revealed,
    output logic [NUM_TILES-1:0] matched,
    output logic                 busy,
    output logic [IDX_W-1:0]     score,
    output logic [7:0]           moves,
    output logic                 gameOver
);

    localparam int TMR_W = timer_width(SHOW_CYCLES);

    turn_state_t          r_state;
    turn_state_t          w_state_nxt;
    logic [NUM_TILES-1:0] r_revealed;
    logic [NUM_TILES-1:0] r_matched;
    logic [IDX_W-1:0]     r_score;
    logic [7:0]           r_moves;
    logic [IDX_W-1:0]     r_idx1;
    logic [IDX_W-1:0]     r_idx2;
    logic [VAL_W-1:0]     r_val1;
    logic [VAL_W-1:0]     r_val2;
    logic                 r_busy;

    logic [NUM_TILES-1:0] w_sel_mask;
    logic [NUM_TILES-1:0] w_pair_mask;
    logic                 w_in_range;
    logic                 w_sel_ok;
    logic                 w_last_pair;
    logic                 w_limit_hit;
    logic                 w_tmr_done;

    logic                 w_clear;
    logic                 w_take1;
    logic                 w_take2;
    logic                 w_cap1;
    logic                 w_cap2;
    logic                 w_hit;
    logic                 w_miss;
    logic                 w_show_end;

    // Masks rather than variable bit-indexing so out-of-range indices simply select nothing.
    assign w_sel_mask  = NUM_TILES'(1) << sel_idx;
    assign w_pair_mask = (NUM_TILES'(1) << r_idx1) | (NUM_TILES'(1) << r_idx2);
    assign w_in_range  = (32'(sel_idx) < NUM_TILES);
    assign w_sel_ok    = sel_valid && w_in_range &&
                         (((r_revealed | r_matched) & w_sel_mask) == '0);
    assign w_last_pair = ((32'(r_score) + 32'd1) == (NUM_TILES / 2));

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_take1     = 1'b0;
        w_take2     = 1'b0;
        w_cap1      = 1'b0;
        w_cap2      = 1'b0;
        w_hit       = 1'b0;
        w_miss      = 1'b0;
        w_show_end  = 1'b0;
        if (!ingameOn) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_clear     = 1'b1;
                    w_state_nxt = PICK1;
                end
                PICK1: begin
                    if (w_sel_ok) begin
                        w_take1     = 1'b1;
                        w_state_nxt = FETCH1;
                    end
                end
                FETCH1: w_state_nxt = LATCH1;
                LATCH1: begin
                    w_cap1      = 1'b1;
                    w_state_nxt = PICK2;
                end
                PICK2: begin
                    if (w_sel_ok) begin
                        w_take2     = 1'b1;
                        w_state_nxt = FETCH2;
                    end
                end
                FETCH2: w_state_nxt = LATCH2;
                LATCH2: begin
                    w_cap2      = 1'b1;
                    w_state_nxt = CMP;
                end
                CMP: begin
                    if (r_val1 == r_val2) begin
                        w_hit       = 1'b1;
                        w_state_nxt = w_last_pair ? DONE : PICK1;
                    end else begin
                        w_miss      = 1'b1;
                        w_state_nxt = SHOW;
                    end
                end
                SHOW: begin
                    if (w_tmr_done) begin
                        w_show_end  = 1'b1;
                        w_state_nxt = w_limit_hit ? DONE : PICK1;
                    end
                end
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= !((w_state_nxt == PICK1) || (w_state_nxt == PICK2));
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_revealed <= '0;
            r_matched  <= '0;
            r_score    <= '0;
            r_moves    <= '0;
        end else if (w_clear) begin
            r_revealed <= '0;
            r_matched  <= '0;
            r_score    <= '0;
            r_moves    <= '0;
        end else begin
            if (w_take1 || w_take2) begin
                r_revealed <= r_revealed | w_sel_mask;
            end
            if (w_hit || w_show_end) begin
                r_revealed <= r_revealed & ~w_pair_mask;
            end
            if (w_hit) begin
                r_matched <= r_matched | w_pair_mask;
                r_score   <= r_score + 1'b1;
            end
            if ((w_hit || w_miss) && (r_moves != 8'hFF)) begin
                r_moves <= r_moves + 8'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_idx1 <= '0;
            r_idx2 <= '0;
            r_val1 <= '0;
            r_val2 <= '0;
        end else begin
            if (w_take1) r_idx1 <= sel_idx;
            if (w_take2) r_idx2 <= sel_idx;
            if (w_cap1)  r_val1 <= rd_data;
            if (w_cap2)  r_val2 <= rd_data;
        end
    end

`ifdef MOVE_LIMIT_EN
    localparam int MISS_W = $clog2(MAX_MISSES + 1);

    logic [MISS_W-1:0] r_misses;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_misses <= '0;
        end else if (w_clear) begin
            r_misses <= '0;
        end else if (w_miss && (r_misses != MISS_W'(MAX_MISSES))) begin
            r_misses <= r_misses + 1'b1;
        end
    end

    assign w_limit_hit = (r_misses == MISS_W'(MAX_MISSES));
`else
    assign w_limit_hit = 1'b0;
`endif

    tile_show_timer #(
        .WIDTH (TMR_W)
    ) u_show_timer (
        .clk        (CLOCK_50),
        .rst_n      (resetn),
        .i_load     (w_miss),
        .i_load_val (TMR_W'(SHOW_CYCLES - 1)),
        .i_en       (r_state == SHOW),
        .o_done     (w_tmr_done)
    );

    assign rd_en    = (r_state == FETCH1) || (r_state == FETCH2);
    assign rd_addr  = (r_state == FETCH1) ? r_idx1 :
                      (r_state == FETCH2) ? r_idx2 : '0;
    assign revealed = r_revealed;
    assign matched  = r_matched;
    assign busy     = r_busy;
    assign score    = r_score;
    assign moves    = r_moves;
    assign gameOver = (r_state == DONE);

endmodule

// File: tb/tb_tile_turn_ctrl.sv
// Directed + randomized bench for tile_turn_ctrl against a turn-level reference model.
module tb_tile_turn_ctrl;

    localparam int NT   = 16;
    localparam int IW   = 5;
    localparam int SHOW = 10;
`ifdef MOVE_LIMIT_EN
    localparam int MAXM = 2;
`endif

    logic          CLOCK_50 = 1'b0;
    logic          resetn   = 1'b0;
    logic          ingameOn = 1'b0;
    logic          sel_valid = 1'b0;
    logic [IW-1:0] sel_idx  = '0;
    logic          rd_en;
    logic [IW-1:0] rd_addr;
    logic [2:0]    rd_data;
    logic [NT-1:0] revealed;
    logic [NT-1:0] matched;
    logic          busy;
    logic [IW-1:0] score;
    logic [7:0]    moves;
    logic          gameOver;

    int checks   = 0;
    int failures = 0;
    int board [32];
    int reads [$];

    logic [NT-1:0] m_rev;
    logic [NT-1:0] m_mat;
    int            m_score;
    int            m_moves;
    int            m_misses;
    bit            m_done;

    tile_turn_ctrl #(
        .NUM_TILES   (NT),
        .IDX_W       (IW),
        .VAL_W       (3),
        .SHOW_CYCLES (SHOW)
`ifdef MOVE_LIMIT_EN
        ,
        .MAX_MISSES  (MAXM)
`endif
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .ingameOn (ingameOn),
        .sel_valid(sel_valid),
        .sel_idx  (sel_idx),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .revealed (revealed),
        .matched  (matched),
        .busy     (busy),
        .score    (score),
        .moves    (moves),
        .gameOver (gameOver)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Board memory: registered read, data valid the cycle after rd_en.
    always @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) rd_data <= 3'd0;
        else if (rd_en) rd_data <= 3'(board[rd_addr]);
    end

    always @(posedge CLOCK_50) begin
        if (resetn && rd_en) reads.push_back(int'(rd_addr));
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_revealed"}, 32'(revealed), 32'(m_rev));
        chk({tag, "_matched"},  32'(matched),  32'(m_mat));
        chk({tag, "_score"},    32'(score),    m_score);
        chk({tag, "_moves"},    32'(moves),    m_moves);
        chk({tag, "_gameOver"}, 32'(gameOver), 32'(m_done));
        chk({tag, "_busy"},     32'(busy),     32'(m_done));
    endtask

    task automatic model_new_game();
        m_rev = '0; m_mat = '0; m_score = 0; m_moves = 0; m_misses = 0; m_done = 0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse(input int idx);
        sel_idx   = IW'(idx);
        sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
    endtask

    // Random tile that is neither face-up nor matched, or -1 if none.
    function automatic int free_tile(input int excl);
        int cand [$];
        for (int i = 0; i < NT; i++)
            if (!m_rev[i] && !m_mat[i] && i != excl) cand.push_back(i);
        if (cand.size() == 0) return -1;
        return cand[$urandom_range(0, cand.size() - 1)];
    endfunction

    task automatic first_pick(input int a);
        wait_ready("pick1");
        reads.delete();
        pulse(a);
        m_rev[a] = 1'b1;
        chk("rd_en1", 32'(rd_en), 32'd1);
        chk("rd_addr1", 32'(rd_addr), a);
        wait_ready("pick2");
        chk("rev_after1", 32'(revealed), 32'(m_rev));
    endtask

    task automatic second_pick(input int a, input int b);
        int t;
        pulse(b);
        m_rev[b] = 1'b1;
        chk("rd_en2", 32'(rd_en), 32'd1);
        chk("rd_addr2", 32'(rd_addr), b);
        t = free_tile(-1);
        if (t >= 0) begin
            sel_idx = IW'(t);
            sel_valid = 1'b1;
        end
        tick();
        sel_valid = 1'b0;
        tick();
        chk("mat_before_cmp", 32'(matched), 32'(m_mat));
        chk("moves_before_cmp", 32'(moves), m_moves);
        tick();
        if (m_moves < 255) m_moves++;
        chk("read_count", reads.size(), 2);
        if (reads.size() == 2) begin
            chk("read0_addr", reads[0], a);
            chk("read1_addr", reads[1], b);
        end
        if (board[a] == board[b]) begin
            m_rev[a] = 1'b0; m_rev[b] = 1'b0;
            m_mat[a] = 1'b1; m_mat[b] = 1'b1;
            m_score++;
            m_done = (m_score == NT / 2);
            check_all("hit");
        end else begin
            m_misses++;
            for (int k = 0; k < SHOW; k++) begin
                chk("show_revealed", 32'(revealed), 32'(m_rev));
                chk("show_busy", 32'(busy), 32'd1);
                if (k == SHOW - 1) begin
                    t = free_tile(-1);
                    if (t >= 0) begin
                        sel_idx = IW'(t);
                        sel_valid = 1'b1;
                    end
                end
                tick();
                sel_valid = 1'b0;
            end
            m_rev[a] = 1'b0; m_rev[b] = 1'b0;
`ifdef MOVE_LIMIT_EN
            m_done = (m_misses == MAXM);
`endif
            check_all("show_end");
        end
    endtask

    task automatic do_turn(input int a, input int b);
        first_pick(a);
        second_pick(a, b);
    endtask

    initial begin
        int rest [$];
        int pos  [$];
        int v, j, tmp, a, b, guard;

        // Tiles 3/7 hold 5/5, tiles 2/4 hold 1/6; everything else random but pair-complete.
        for (int i = 0; i < 32; i++) board[i] = 0;
        board[3] = 5; board[7] = 5; board[2] = 1; board[4] = 6;
        rest.push_back(1);
        rest.push_back(6);
        for (int p = 0; p < 5; p++) begin
            v = $urandom_range(0, 7);
            rest.push_back(v);
            rest.push_back(v);
        end
        for (int i = rest.size() - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = rest[i]; rest[i] = rest[j]; rest[j] = tmp;
        end
        for (int i = 0; i < NT; i++)
            if (i != 2 && i != 3 && i != 4 && i != 7) pos.push_back(i);
        for (int i = 0; i < pos.size(); i++) board[pos[i]] = rest[i];

        model_new_game();
        repeat (3) tick();
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gameOver", 32'(gameOver), 32'd0);
        check_all("rst");

        resetn = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd1);
        ingameOn = 1'b1;
        tick();
        check_all("start");

        do_turn(3, 7);
        do_turn(2, 4);

`ifdef MOVE_LIMIT_EN
        do_turn(free_tile(-1) == 2 ? 2 : 2, 4);
        repeat (3) begin
            tick();
            check_all("limit_done_hold");
        end
`else
        // Rejected selections: matched tile, out of range, then same tile twice.
        reads.delete();
        pulse(3);
        pulse(20);
        pulse(31);
        repeat (3) tick();
        chk("rej_pick1_busy", 32'(busy), 32'd0);
        chk("rej_pick1_reads", reads.size(), 0);
        chk("rej_pick1_rev", 32'(revealed), 32'(m_rev));
        a = free_tile(-1);
        first_pick(a);
        reads.delete();
        pulse(a);
        pulse(7);
        pulse(NT + 1);
        repeat (3) tick();
        chk("rej_pick2_busy", 32'(busy), 32'd0);
        chk("rej_pick2_reads", reads.size(), 0);
        chk("rej_pick2_rev", 32'(revealed), 32'(m_rev));
        b = free_tile(a);
        reads.delete();
        reads.push_back(a);
        second_pick(a, b);

        for (int t = 0; t < 4 && !m_done; t++) begin
            a = free_tile(-1);
            first_pick(a);
            b = free_tile(a);
            second_pick(a, b);
        end

        guard = 0;
        while (!m_done && guard < 20) begin
            a = -1; b = -1;
            for (int i = 0; i < NT && b < 0; i++)
                for (int k = i + 1; k < NT && b < 0; k++)
                    if (!m_mat[i] && !m_mat[k] && board[i] == board[k]) begin
                        a = i; b = k;
                    end
            do_turn(a, b);
            guard++;
        end
        chk("clear_score", 32'(score), 32'(NT / 2));
        repeat (3) begin
            tick();
            check_all("done_hold");
        end

        ingameOn = 1'b0;
        tick();
        chk("exit_gameOver", 32'(gameOver), 32'd0);
        chk("exit_busy", 32'(busy), 32'd1);
        chk("exit_matched_held", 32'(matched), 32'(m_mat));
        chk("exit_score_held", 32'(score), m_score);
        ingameOn = 1'b1;
        tick();
        model_new_game();
        check_all("restart");

        // Abort a turn while the mismatched pair is on show.
        first_pick(2);
        pulse(4);
        m_rev[4] = 1'b1;
        repeat (5) tick();
        chk("abort_in_show_busy", 32'(busy), 32'd1);
        chk("abort_in_show_rev", 32'(revealed), 32'(m_rev));
        ingameOn = 1'b0;
        tick();
        m_moves = 1;
        chk("abort_idle_busy", 32'(busy), 32'd1);
        chk("abort_idle_gameOver", 32'(gameOver), 32'd0);
        chk("abort_rev_held", 32'(revealed), 32'(m_rev));
        chk("abort_moves_held", 32'(moves), m_moves);
        repeat (2) tick();
        ingameOn = 1'b1;
        tick();
        model_new_game();
        check_all("reentry");
        do_turn(3, 7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
